// File: rtl/addsub_pkg.sv
// Shared types for the multi-precision add/sub sequencer: FSM state encoding
// and the slice-index width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Keeps the index at least one bit wide even for degenerate WORDS values.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// N-bit add/subtract slice: sum = a + (b ^ {N{sub}}) + cin, with carry out.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] total;

    assign total       = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/sub sequencer: walks one N-bit slice LSB-first per clock.
// Optional zero flag is built only when ADDSUB_SEQ_ZERO_FLAG_EN is defined.
//
// state | meaning
// IDLE  | ready=1, waiting for start; operands captured on accept
// RUN   | one slice per edge, carry chained through the carry register
// DONE  | one-cycle done pulse, start ignored
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic [N*WORDS-1:0] op_a,
    input  logic [N*WORDS-1:0] op_b,
    output logic               ready,
    output logic               done,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf,
    output logic               zero
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           sub_r;

    logic [N-1:0]   s_a;
    logic [N-1:0]   s_b;
    logic [N-1:0]   s_sum;
    logic           s_cout;
    logic           last;
    logic           ovf_next;

    assign s_a  = a_r[int'(idx) * N +: N];
    assign s_b  = b_r[int'(idx) * N +: N];
    assign last = (idx == IW'(WORDS - 1));

    // MSB of the final result comes straight from the last slice's sum.
    assign ovf_next = (a_r[W-1] == (b_r[W-1] ^ sub_r)) && (s_sum[N-1] != a_r[W-1]);

    addsub_slice #(.N(N)) u_slice (
        .a    (s_a),
        .b    (s_b),
        .sub  (sub_r),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    logic zero_r;
    logic zero_next;

    // Lower slices are already final when the MSB slice is computed.
    assign zero_next = (result[W-N-1:0] == '0) && (s_sum == '0);
    assign zero      = zero_r;
`else
    assign zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            ready  <= 1'b1;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            zero_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r    <= op_a;
                        b_r    <= op_b;
                        sub_r  <= sub;
                        carry  <= sub;
                        idx    <= '0;
                        result <= '0;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[int'(idx) * N +: N] <= s_sum;
                    carry <= s_cout;
                    if (last) begin
                        idx   <= '0;
                        cout  <= s_cout;
                        ovf   <= ovf_next;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
                        zero_r <= zero_next;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl (N=4, WORDS=4): directed vectors push
// expectations, a negedge monitor pops and compares on every done pulse.
module tb_addsub_seq_ctrl;

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        ready, done, cout, ovf, zero;
    logic [15:0] result;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    addsub_seq_ctrl #(.N(4), .WORDS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    // Monitor: compare on every done pulse, independent of stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_cout"}, 16'(cout), 16'(e.c));
                    chk({e.name, "_ovf"}, 16'(ovf), 16'(e.o));
                    chk({e.name, "_zero"}, 16'(zero), 16'(e.z & ZEN));
                    chk({e.name, "_latency"}, 16'(cyc), 16'(e.due));
                    chk({e.name, "_ready_in_done"}, 16'(ready), 16'd0);
                end
                chk("done_width", 16'(prev_done), 16'd0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
    endtask

    task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] r, input logic c, input logic o, input logic z, input bit push);
        exp_t e;
        wait_ready();
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        if (push) begin
            e.res = r; e.c = c; e.o = o; e.z = z; e.due = cyc + 1 + 4; e.name = name;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int c0;
        exp_t e;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_result", result, 16'h0000);
        chk("reset_cout", 16'(cout), 16'd0);
        chk("reset_ovf", 16'(ovf), 16'd0);
        chk("reset_zero", 16'(zero), 16'd0);
        chk("reset_done", 16'(done), 16'd0);
        chk("reset_ready", 16'(ready), 16'd1);

        issue("add",        16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b1);
        issue("sub_nobrw",  16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
        issue("sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        issue("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("ovf_sub",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);

        // start pulsed while busy must be ignored
        issue("busy",       16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op_a  = 16'hAAAA;
        op_b  = 16'h5555;
        sub   = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;

        // reset in the middle of RUN, at idx=2
        issue("abort",      16'h4321, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_ready", 16'(ready), 16'd1);
        chk("midrun_rst_result", result, 16'h0000);
        chk("midrun_rst_done", 16'(done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        issue("wrap_zero",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

        // start held high: accepts every 6 cycles
        wait_ready();
        op_a  = 16'h0001;
        op_b  = 16'h0002;
        sub   = 1'b0;
        start = 1'b1;
        c0    = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.res = 16'h0003; e.c = 1'b0; e.o = 1'b0; e.z = 1'b0;
            e.due = c0 + 6 * k + 4; e.name = "b2b";
            q.push_back(e);
        end
        repeat (13) @(negedge clk);
        start = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
